axil_class_output_v2: RTL and testbench
=======================================

Name: axil_class_output_v2

Overview:
- Parametrised successor to the fixed 10-class final-output collector at the tail of the MNIST inference pipeline.
- Snapshots N_CH signed class scores in one AXI-Stream handshake, then streams them out in order with proper backpressure and TLAST.
- Computes argmax and maximum value serially while streaming.
- Exposes scores, status, argmax and control over AXI4-Lite; raises an interrupt on completion.

Parameters:
- N_CH, 10, number of class channels (2..16).
- DATA_W, 32, score width; signed two's complement; must be ≤32.
- IDX_W, 4, width of the argmax index; must satisfy 2^IDX_W ≥ N_CH.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous assert, active-low.
- s_axil_aw*/w*/b*/ar*/r*  -  std  AXI4-Lite slave; 7-bit address, 32-bit data, wstrb ignored, prot ignored.
- a_tdata  in  N_CH*DATA_W  packed class scores; channel k at [k*DATA_W +: DATA_W].
- a_tvalid  in  N_CH  per-channel valid.
- a_tready  out  N_CH  per-channel ready; all bits equal.
- x_tdata  out  DATA_W  serialized scores.
- x_tvalid  out  1  output stream valid.
- x_tready  in  1  output stream ready.
- x_tlast  out  1  high on beat N_CH-1.
- irq  out  1  level interrupt; equals done & irq_en.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, score bank 0, argmax 0, maxval 0, irq_en 0, done 0. Reset mid-operation discards any partial result; no beat completes after reset asserts.
- FSM states are IDLE, STREAM and DONE.
- IDLE:
  - a_tready = all_valid (AND of a_tvalid).
  - On all_valid, capture every channel into the score bank in that cycle and go to STREAM with idx=0.
  - Partial valid never captures anything.
- STREAM:
  - x_tvalid=1; x_tdata=bank[idx]; x_tlast=(idx==N_CH-1).
  - x_tdata must hold stable while x_tready=0.
  - On each x_tvalid&x_tready beat:
    - idx=0: running max = bank[0], argmax = 0.
    - idx>0: update only if bank[idx] > running max (signed, strict), so ties resolve to the lowest index.
    - Increment idx.
  - The beat with tlast moves to DONE and sets done=1.
  - First beat presents in the cycle after capture, so capture-to-first-beat latency is 1 cycle.
  - Zero-bubble: one beat per cycle when x_tready stays high.
- DONE:
  - a_tready=0, x_tvalid=0; hold the results.
  - A CTRL write with bit0=1 clears done and returns to IDLE on the cycle after the write handshake.
- a_tready=0 in STREAM and DONE, so new inputs are backpressured.
- AXI4-Lite write channel:
  - awready=wready=1 for a single cycle when awvalid&wvalid&~bvalid.
  - bvalid rises the next cycle and holds until bready.
  - bresp is always OKAY.
- AXI4-Lite read channel:
  - arready pulses for one cycle when arvalid&~rvalid&~arready.
  - rdata/rvalid are registered the cycle after the handshake and held until rready.
  - rresp is always OKAY.
- Address map (byte offsets):
  - 0x00+4k, k<N_CH: bank[k], sign-extended to 32 bits; read-only.
  - Offsets with k≥N_CH below 0x40: read 0.
  - 0x40 STATUS (RO): bit0 done, bits2:1 state (IDLE 0, STREAM 1, DONE 2), bit3 all_valid; other bits 0.
  - 0x44 CTRL: bit0 ack (write-1-pulse, reads 0), bit1 irq_en (R/W), bit2 soft_clear (write-1-pulse, reads 0).
  - 0x48 ARGMAX (RO): zero-extended argmax; valid only when done=1.
  - 0x4C MAXVAL (RO): sign-extended max value.
  - Unmapped addresses read 0; writes to them are ignored.
- soft_clear: same effect as reset on FSM, bank and results, except irq_en keeps its value; takes effect the cycle after the write handshake, including mid-STREAM.
- Write to CTRL while in IDLE or STREAM with ack=1: ack is ignored; irq_en updates normally.
- Simultaneous AXI-Lite read and capture: a read handshaking in the same cycle as capture returns the pre-capture values.

Test Plan:
- Single inference: N_CH=10, scores k*3-5, tvalid all high, x_tready=1 -> a_tready high for exactly 1 cycle; 10 consecutive beats -5,-2,...,22; tlast on beat 9; ARGMAX reads 9, MAXVAL reads 22, STATUS reads 0x5.
- Ties and negatives: scores all -7 except ch3=ch6=100 -> ARGMAX reads 3, MAXVAL reads 100; all -1 -> ARGMAX 0, MAXVAL 0xFFFFFFFF.
- Backpressure: x_tready toggles 1010..., then stalls 5 cycles mid-stream -> x_tdata stable during stalls, no beat lost or duplicated, 10 beats total, a_tready stays 0 throughout.
- Partial valid: only 9 of 10 tvalid high for 20 cycles -> a_tready 0, STATUS state IDLE, bit3=0; 10th tvalid rises -> capture occurs the same cycle.
- Interrupt/ack: write CTRL=0x2, run an inference -> irq rises the cycle done sets; write CTRL=0x1 -> irq falls, state IDLE, next inference accepted.
- Reset/clear mid-stream: aresetn low after beat 4 -> all outputs 0 immediately, no further beats; repeat with soft_clear -> same, irq_en preserved; N_CH=4 variant -> tlast on beat 3, reads of 0x10 return 0.

Source files
------------

// File: rtl/axil_class_output_v2_if.sv
// AXI4-Lite bus bundle for the class-output collector: 7-bit address, 32-bit data.
interface axil_class_output_v2_if;
    logic [6:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [6:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_class_output_v2.sv
// Final-output collector: snapshots N_CH class scores, streams them out with a serial
// argmax/max, and exposes scores, status and control over AXI4-Lite.
module axil_class_output_v2 #(
    parameter int N_CH   = 10,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axil_class_output_v2_if.slave    s_axil,
    input  logic [N_CH*DATA_W-1:0]   a_tdata,
    input  logic [N_CH-1:0]          a_tvalid,
    output logic [N_CH-1:0]          a_tready,
    output logic [DATA_W-1:0]        x_tdata,
    output logic                     x_tvalid,
    input  logic                     x_tready,
    output logic                     x_tlast,
    output logic                     irq
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_argmax;
    logic [DATA_W-1:0]  r_maxval;
    logic               r_done;
    logic               r_irq_en;
    logic               r_awready;
    logic               r_bvalid;
    logic               r_arready;
    logic               r_rvalid;
    logic [31:0]        r_rdata;

    logic [31:0]        w_bank_rd [16];
    logic [DATA_W-1:0]  w_cur;
    logic [31:0]        w_rd_mux;
    logic               w_all_valid;
    logic               w_capture;
    logic               w_wr_hs;
    logic               w_rd_hs;
    logic               w_ctrl_wr;
    logic               w_ack;
    logic               w_soft_clear;
    logic               w_unused;

    assign w_all_valid  = &a_tvalid;
    assign w_capture    = w_all_valid && (r_state == S_IDLE);
    assign w_wr_hs      = r_awready && s_axil.awvalid && s_axil.wvalid;
    assign w_rd_hs      = r_arready && s_axil.arvalid;
    assign w_ctrl_wr    = w_wr_hs && (s_axil.awaddr[6:2] == 5'h11);
    assign w_ack        = w_ctrl_wr && s_axil.wdata[0];
    assign w_soft_clear = w_ctrl_wr && s_axil.wdata[2];
    assign w_unused     = ^{s_axil.awprot, s_axil.arprot, s_axil.wstrb,
                            s_axil.wdata[31:3], s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    // Score bank, padded to 16 sign-extended words so address decode and the
    // stream mux can index it directly; slots past N_CH read as zero.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ch
            if (gi < N_CH) begin : g_live
                logic [DATA_W-1:0] r_score;
                always_ff @(posedge aclk or negedge aresetn) begin
                    if (!aresetn) begin
                        r_score <= '0;
                    end else if (w_soft_clear) begin
                        r_score <= '0;
                    end else if (w_capture) begin
                        r_score <= a_tdata[gi*DATA_W +: DATA_W];
                    end
                end
                assign w_bank_rd[gi] = 32'($signed(r_score));
            end else begin : g_pad
                assign w_bank_rd[gi] = '0;
            end
        end
    endgenerate

    assign w_cur    = w_bank_rd[4'(r_idx)][DATA_W-1:0];
    assign x_tvalid = (r_state == S_STREAM);
    assign x_tdata  = x_tvalid ? w_cur : '0;
    assign x_tlast  = x_tvalid && (r_idx == IDX_W'(N_CH - 1));
    // Gated by reset so nothing is offered to the upstream while held in reset.
    assign a_tready = {N_CH{w_capture && aresetn}};
    assign irq      = r_done && r_irq_en;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_argmax <= '0;
            r_maxval <= '0;
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= s_axil.wdata[1];
            end
            if (w_soft_clear) begin
                r_state  <= S_IDLE;
                r_idx    <= '0;
                r_argmax <= '0;
                r_maxval <= '0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_all_valid) begin
                            r_idx   <= '0;
                            r_state <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (x_tready) begin
                            // Strict compare keeps the lowest index on ties.
                            if (r_idx == '0) begin
                                r_maxval <= w_cur;
                                r_argmax <= '0;
                            end else if ($signed(w_cur) > $signed(r_maxval)) begin
                                r_maxval <= w_cur;
                                r_argmax <= r_idx;
                            end
                            r_idx <= r_idx + 1'b1;
                            if (x_tlast) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (w_ack) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (!s_axil.araddr[6]) begin
            w_rd_mux = w_bank_rd[s_axil.araddr[5:2]];
        end else begin
            case (s_axil.araddr[5:2])
                4'h0:    w_rd_mux = {28'd0, w_all_valid, r_state, r_done};
                4'h1:    w_rd_mux = {30'd0, r_irq_en, 1'b0};
                4'h2:    w_rd_mux = 32'(r_argmax);
                4'h3:    w_rd_mux = 32'($signed(r_maxval));
                default: w_rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= s_axil.awvalid && s_axil.wvalid && !r_bvalid && !r_awready;
            if (r_bvalid && s_axil.bready) begin
                r_bvalid <= 1'b0;
            end else if (w_wr_hs) begin
                r_bvalid <= 1'b1;
            end
            r_arready <= s_axil.arvalid && !r_rvalid && !r_arready;
            if (r_rvalid && s_axil.rready) begin
                r_rvalid <= 1'b0;
            end else if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end
        end
    end

    assign s_axil.awready = r_awready;
    assign s_axil.wready  = r_awready;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = 2'b00;
    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = 2'b00;
endmodule

// File: tb/tb_axil_class_output_v2.sv
// Directed bench for axil_class_output_v2: a 10-channel instance for the main
// scenarios and a 4-channel instance for the narrow-configuration boundary.
module tb_axil_class_output_v2;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    axil_class_output_v2_if bus();
    axil_class_output_v2_if bus4();

    logic [319:0] a_tdata;
    logic [9:0]   a_tvalid;
    logic [9:0]   a_tready;
    logic [31:0]  x_tdata;
    logic         x_tvalid, x_tready, x_tlast, irq;

    logic [127:0] a4_tdata;
    logic [3:0]   a4_tvalid;
    logic [3:0]   a4_tready;
    logic [31:0]  x4_tdata;
    logic         x4_tvalid, x4_tready, x4_tlast, irq4;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_s [10];

    axil_class_output_v2 #(.N_CH(10), .DATA_W(32), .IDX_W(4)) dut (
        .aclk(clk), .aresetn(aresetn), .s_axil(bus),
        .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
        .x_tlast(x_tlast), .irq(irq)
    );

    axil_class_output_v2 #(.N_CH(4), .DATA_W(32), .IDX_W(2)) dut4 (
        .aclk(clk), .aresetn(aresetn), .s_axil(bus4),
        .a_tdata(a4_tdata), .a_tvalid(a4_tvalid), .a_tready(a4_tready),
        .x_tdata(x4_tdata), .x_tvalid(x4_tvalid), .x_tready(x4_tready),
        .x_tlast(x4_tlast), .irq(irq4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int pat, input int cyc);
        if (pat == 0) return 1'b1;
        if (cyc < 6) return (cyc % 2) == 0;
        return cyc >= 11;
    endfunction

    task automatic axil_write(input logic [6:0] a, input logic [31:0] d);
        int n = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = '1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
        check("wr_awready", bus.awready, 1);
        check("wr_wready", bus.wready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.bvalid && n < 20);
        check("wr_bvalid", bus.bvalid, 1);
        check("wr_bresp", 32'(bus.bresp), 0);
        @(posedge clk); #1;
        bus.bready = 1'b0;
        $display("wr  0x%02h <- 0x%08h", a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        int n = 0;
        logic [31:0] d;
        bus.araddr = a; bus.arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
        check("rd_arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 20);
        check("rd_rvalid", bus.rvalid, 1);
        d = bus.rdata;
        check(tag, d, exp);
        @(posedge clk); #1;
        bus.rready = 1'b0;
        $display("rd  0x%02h -> 0x%08h (%s)", a, d, tag);
    endtask

    task automatic rd4_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        int n = 0;
        logic [31:0] d;
        bus4.araddr = a; bus4.arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus4.arready && n < 20);
        check("rd4_arready", bus4.arready, 1);
        @(posedge clk); #1;
        bus4.arvalid = 1'b0; bus4.rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus4.rvalid && n < 20);
        check("rd4_rvalid", bus4.rvalid, 1);
        d = bus4.rdata;
        check(tag, d, exp);
        @(posedge clk); #1;
        bus4.rready = 1'b0;
        $display("rd4 0x%02h -> 0x%08h (%s)", a, d, tag);
    endtask

    // Capture exp_s, then stream up to nmax beats under ready pattern pat.
    task automatic infer(input int pat, input int nmax);
        int nb = 0;
        logic held = 1'b0;
        logic [31:0] prev_d = '0;
        for (int k = 0; k < 10; k++) a_tdata[k*32 +: 32] = exp_s[k];
        a_tvalid = '1;
        @(negedge clk);
        check("a_tready_cap", 32'(a_tready), 32'h3FF);
        check("xvalid_pre", x_tvalid, 0);
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 60 && nb < nmax; cyc++) begin
            x_tready = rdy(pat, cyc);
            @(negedge clk);
            if (cyc == 0) check("first_beat_lat", x_tvalid, 1);
            check("a_tready_busy", 32'(a_tready), 0);
            if (held) check("hold", x_tdata, prev_d);
            if (x_tvalid && x_tready) begin
                check("beat", x_tdata, exp_s[nb]);
                check("tlast", x_tlast, (nb == 9));
                check("irq_busy", irq, 0);
                nb++;
            end
            held = x_tvalid && !x_tready;
            prev_d = x_tdata;
            @(posedge clk); #1;
        end
        a_tvalid = '0;
        check("nbeats", nb, nmax);
        $display("stream pat=%0d beats=%0d", pat, nb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e4 [4];
        e4[0] = 10; e4[1] = -20; e4[2] = 30; e4[3] = 5;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0;
        bus.rready = 0;
        bus4.awaddr = '0; bus4.awprot = '0; bus4.awvalid = 0; bus4.wdata = '0; bus4.wstrb = '0;
        bus4.wvalid = 0; bus4.bready = 0; bus4.araddr = '0; bus4.arprot = '0; bus4.arvalid = 0;
        bus4.rready = 0;
        a_tdata = '0; a_tvalid = '1; x_tready = 1'b1;
        a4_tdata = '0; a4_tvalid = '1; x4_tready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_tready", 32'(a_tready), 0);
        check("rst_xvalid", x_tvalid, 0);
        check("rst_xdata", x_tdata, 0);
        check("rst_irq", irq, 0);
        a_tvalid = '0; a4_tvalid = '0;
        aresetn = 1'b1;
        @(posedge clk); #1;
        rd_chk("rst_status", 7'h40, 0);
        rd_chk("rst_argmax", 7'h48, 0);
        rd_chk("rst_maxval", 7'h4C, 0);
        rd_chk("rst_ctrl", 7'h44, 0);

        // Single inference, ascending scores
        for (int k = 0; k < 10; k++) exp_s[k] = k*3 - 5;
        infer(0, 10);
        @(negedge clk);
        check("done_xvalid", x_tvalid, 0);
        @(posedge clk); #1;
        rd_chk("t1_argmax", 7'h48, 9);
        rd_chk("t1_maxval", 7'h4C, 22);
        rd_chk("t1_status", 7'h40, 32'h5);
        rd_chk("t1_bank0", 7'h00, 32'hFFFF_FFFB);
        rd_chk("t1_bank9", 7'h24, 22);
        rd_chk("t1_unmapped", 7'h50, 0);
        axil_write(7'h44, 32'h1);
        rd_chk("t1_status_ack", 7'h40, 0);

        // Ties resolve to lowest index
        for (int k = 0; k < 10; k++) exp_s[k] = -7;
        exp_s[3] = 100; exp_s[6] = 100;
        infer(0, 10);
        rd_chk("tie_argmax", 7'h48, 3);
        rd_chk("tie_maxval", 7'h4C, 100);
        axil_write(7'h44, 32'h1);
        for (int k = 0; k < 10; k++) exp_s[k] = -1;
        infer(0, 10);
        rd_chk("neg_argmax", 7'h48, 0);
        rd_chk("neg_maxval", 7'h4C, 32'hFFFF_FFFF);
        axil_write(7'h44, 32'h1);

        // Backpressure: alternating ready then a 5-cycle stall
        for (int k = 0; k < 10; k++) exp_s[k] = 100 - 7*k;
        infer(1, 10);
        rd_chk("bp_argmax", 7'h48, 0);
        rd_chk("bp_maxval", 7'h4C, 100);
        axil_write(7'h44, 32'h1);

        // Partial valid never captures
        a_tvalid = 10'h1FF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("partial_a_tready", 32'(a_tready), 0);
            @(posedge clk); #1;
        end
        rd_chk("partial_status", 7'h40, 0);
        for (int k = 0; k < 10; k++) exp_s[k] = k*3 - 5;
        infer(0, 10);
        rd_chk("partial_argmax", 7'h48, 9);
        axil_write(7'h44, 32'h1);

        // Interrupt and ack
        axil_write(7'h44, 32'h2);
        rd_chk("irq_ctrl", 7'h44, 32'h2);
        for (int k = 0; k < 10; k++) exp_s[k] = (k == 7) ? 50 : k;
        infer(0, 10);
        @(negedge clk);
        check("irq_done", irq, 1);
        @(posedge clk); #1;
        rd_chk("irq_argmax", 7'h48, 7);
        axil_write(7'h44, 32'h1);
        @(negedge clk);
        check("irq_ack", irq, 0);
        @(posedge clk); #1;
        rd_chk("irq_status", 7'h40, 0);
        infer(0, 10);
        axil_write(7'h44, 32'h1);

        // Asynchronous reset after beat 4
        axil_write(7'h44, 32'h2);
        for (int k = 0; k < 10; k++) exp_s[k] = k*3 - 5;
        infer(0, 5);
        a_tvalid = '1;
        aresetn = 1'b0;
        #1;
        check("arst_xvalid", x_tvalid, 0);
        check("arst_xdata", x_tdata, 0);
        check("arst_xlast", x_tlast, 0);
        check("arst_a_tready", 32'(a_tready), 0);
        check("arst_irq", irq, 0);
        repeat (3) begin
            @(negedge clk);
            check("arst_no_beat", x_tvalid, 0);
        end
        a_tvalid = '0;
        aresetn = 1'b1;
        @(posedge clk); #1;
        rd_chk("arst_ctrl", 7'h44, 0);
        rd_chk("arst_status", 7'h40, 0);
        rd_chk("arst_bank0", 7'h00, 0);
        rd_chk("arst_maxval", 7'h4C, 0);

        // Soft clear mid-stream keeps irq_en
        axil_write(7'h44, 32'h2);
        infer(0, 5);
        x_tready = 1'b0;
        axil_write(7'h44, 32'h6);
        x_tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("sclr_no_beat", x_tvalid, 0);
        end
        @(posedge clk); #1;
        rd_chk("sclr_status", 7'h40, 0);
        rd_chk("sclr_ctrl", 7'h44, 32'h2);
        rd_chk("sclr_bank0", 7'h00, 0);
        rd_chk("sclr_maxval", 7'h4C, 0);
        rd_chk("sclr_argmax", 7'h48, 0);
        axil_write(7'h44, 32'h0);

        // Four-channel configuration
        for (int k = 0; k < 4; k++) a4_tdata[k*32 +: 32] = e4[k];
        a4_tvalid = '1;
        @(negedge clk);
        check("n4_a_tready", 32'(a4_tready), 32'hF);
        @(posedge clk); #1;
        a4_tvalid = '0;
        x4_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("n4_xvalid", x4_tvalid, 1);
            check("n4_beat", x4_tdata, e4[b]);
            check("n4_tlast", x4_tlast, (b == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("n4_done_xvalid", x4_tvalid, 0);
        @(posedge clk); #1;
        rd4_chk("n4_rd_0x10", 7'h10, 0);
        rd4_chk("n4_bank3", 7'h0C, 5);
        rd4_chk("n4_argmax", 7'h48, 2);
        rd4_chk("n4_maxval", 7'h4C, 30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
